regfile_clr_be: RTL and testbench

//   2-read/1-write register file, parametrised in width and depth, for CPU datapath and scratch

---
 rtl/regfile_clr_be_if.sv | 29 ++
 rtl/regfile_clr_be.sv | 87 ++++++++
 tb/tb_regfile_clr_be.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_clr_be_if.sv
// rtl/regfile_clr_be_if.sv - read/write/clear bus of the byte-enable register file
interface regfile_clr_be_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
);
    logic                   i_rf_clr;
    logic [BW_ADDR-1:0]     i_rf_rd_addr0;
    logic [BW_ADDR-1:0]     i_rf_rd_addr1;
    logic [BW_DATA-1:0]     o_rf_rd_data0;
    logic [BW_DATA-1:0]     o_rf_rd_data1;
    logic                   i_rf_wr_en;
    logic [BW_ADDR-1:0]     i_rf_wr_addr;
    logic [BW_DATA-1:0]     i_rf_wr_data;
    logic [BW_DATA/8-1:0]   i_rf_wr_be;
    logic                   o_rf_busy;
    logic                   o_rf_wr_err;

    modport master (
        output i_rf_clr, i_rf_rd_addr0, i_rf_rd_addr1,
        output i_rf_wr_en, i_rf_wr_addr, i_rf_wr_data, i_rf_wr_be,
        input  o_rf_rd_data0, o_rf_rd_data1, o_rf_busy, o_rf_wr_err
    );

    modport slave (
        input  i_rf_clr, i_rf_rd_addr0, i_rf_rd_addr1,
        input  i_rf_wr_en, i_rf_wr_addr, i_rf_wr_data, i_rf_wr_be,
        output o_rf_rd_data0, o_rf_rd_data1, o_rf_busy, o_rf_wr_err
    );
endinterface

// File: rtl/regfile_clr_be.sv
// rtl/regfile_clr_be.sv - 2R/1W register file with byte enables, zero entry and clear sweep
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_clr_be #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    regfile_clr_be_if.slave   rf
);
    localparam int NB    = BW_DATA / 8;
    localparam int DEPTH = 2 ** BW_ADDR;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t               state;
    logic [BW_ADDR-1:0]   clr_addr;
    logic                 wr_err;
    logic                 busy;
    logic                 wr_ok;
    logic [BW_DATA-1:0]   rf_arr [DEPTH];
    logic [BW_ADDR-1:0]   rd_addr [2];
    logic [BW_DATA-1:0]   rd_data [2];

    assign busy  = (state == ST_CLEAR);
    assign wr_ok = rf.i_rf_wr_en && !busy && !(ZERO_REG && (rf.i_rf_wr_addr == '0));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= rf.i_rf_wr_en && busy;
            case (state)
                ST_IDLE: begin
                    if (rf.i_rf_clr)
                        state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    // Last entry swept: the counter wraps back to 0 for the next request.
                    if (&clr_addr) begin
                        clr_addr <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // Storage has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge i_clk) begin
        if (busy) begin
            rf_arr[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++)
                if (rf.i_rf_wr_be[k])
                    rf_arr[rf.i_rf_wr_addr][8*k +: 8] <= rf.i_rf_wr_data[8*k +: 8];
        end
    end

    assign rd_addr[0] = rf.i_rf_rd_addr0;
    assign rd_addr[1] = rf.i_rf_rd_addr1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = rf_arr[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rf.i_rf_wr_addr == rd_addr[p])) begin
                for (int k = 0; k < NB; k++)
                    if (rf.i_rf_wr_be[k])
                        rd_data[p][8*k +: 8] = rf.i_rf_wr_data[8*k +: 8];
            end
`endif
            if (busy || (ZERO_REG && (rd_addr[p] == '0)))
                rd_data[p] = '0;
        end
    end

    assign rf.o_rf_rd_data0 = rd_data[0];
    assign rf.o_rf_rd_data1 = rd_data[1];
    assign rf.o_rf_busy     = busy;
    assign rf.o_rf_wr_err   = wr_err;
endmodule

// File: tb/tb_regfile_clr_be.sv
// tb/tb_regfile_clr_be.sv - scoreboard bench for regfile_clr_be (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_regfile_clr_be;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rstn;
    always #5 i_clk = ~i_clk;

    regfile_clr_be_if #(.BW_DATA(32), .BW_ADDR(5)) rf  ();
    regfile_clr_be_if #(.BW_DATA(32), .BW_ADDR(5)) rf0 ();

    assign rf0.i_rf_clr      = rf.i_rf_clr;
    assign rf0.i_rf_rd_addr0 = rf.i_rf_rd_addr0;
    assign rf0.i_rf_rd_addr1 = rf.i_rf_rd_addr1;
    assign rf0.i_rf_wr_en    = rf.i_rf_wr_en;
    assign rf0.i_rf_wr_addr  = rf.i_rf_wr_addr;
    assign rf0.i_rf_wr_data  = rf.i_rf_wr_data;
    assign rf0.i_rf_wr_be    = rf.i_rf_wr_be;

    regfile_clr_be #(.BW_DATA(32), .BW_ADDR(5), .ZERO_REG(1'b1)) dut (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .rf    (rf.slave)
    );

    regfile_clr_be #(.BW_DATA(32), .BW_ADDR(5), .ZERO_REG(1'b0)) dut0 (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .rf    (rf0.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] z0;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".rd0"},    rf.o_rf_rd_data0,         e.d0);
            chk({e.name, ".rd1"},    rf.o_rf_rd_data1,         e.d1);
            chk({e.name, ".z0_rd0"}, rf0.o_rf_rd_data0,        e.z0);
            chk({e.name, ".busy"},   {31'b0, rf.o_rf_busy},    {31'b0, e.busy});
            chk({e.name, ".wr_err"}, {31'b0, rf.o_rf_wr_err},  {31'b0, e.err});
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic exp_push(input string name, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] z0, input logic busy, input logic err);
        exp_t e;
        e = '{name, d0, d1, z0, busy, err};
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        rf.i_rf_wr_en   = en;
        rf.i_rf_wr_addr = a;
        rf.i_rf_wr_data = d;
        rf.i_rf_wr_be   = be;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rf.i_rf_rd_addr0 = a0;
        rf.i_rf_rd_addr1 = a1;
    endtask

    // Called in the cycle reset is released: 32 busy cycles, then one idle cycle reading 0.
    task automatic sweep_check(input string name, input logic [4:0] a0, input logic [4:0] a1);
        set_rd(a0, a1);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) step();
            exp_push({name, "_busy"}, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        step();
        exp_push({name, "_done"}, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        i_rstn = 1'b0;
        rf.i_rf_clr = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        set_rd(5'd0, 5'd0);
        step();
        step();
        exp_push("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        i_rstn = 1'b1;
        sweep_check("sweep0", 5'd0, 5'd0);

        for (int a = 0; a < 32; a++) begin
            step();
            set_rd(5'(a), 5'(31 - a));
            exp_push("clr_rd", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        step();
        set_rd(5'd3, 5'd3);
        set_wr(1'b1, 5'd3, 32'hAABBCCDD, 4'b1111);
        exp_push("be_w1", BYP ? 32'hAABBCCDD : 32'h0, BYP ? 32'hAABBCCDD : 32'h0,
                 BYP ? 32'hAABBCCDD : 32'h0, 1'b0, 1'b0);
        step();
        set_wr(1'b1, 5'd3, 32'h11223344, 4'b0101);
        exp_push("be_w2", BYP ? 32'hAA22CC44 : 32'hAABBCCDD, BYP ? 32'hAA22CC44 : 32'hAABBCCDD,
                 BYP ? 32'hAA22CC44 : 32'hAABBCCDD, 1'b0, 1'b0);
        step();
        set_wr(1'b1, 5'd3, 32'hFFFFFFFF, 4'b0000);
        exp_push("be_none", 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0);
        step();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        exp_push("be_rd", 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0);

        step();
        set_rd(5'd0, 5'd0);
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'b1111);
        exp_push("zr_w", 32'h0, 32'h0, BYP ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b0);
        step();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        exp_push("zr_rd", 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);

        step();
        set_rd(5'd5, 5'd6);
        set_wr(1'b1, 5'd5, 32'h00001234, 4'b1111);
        exp_push("cb_w5", BYP ? 32'h1234 : 32'h0, 32'h0, BYP ? 32'h1234 : 32'h0, 1'b0, 1'b0);
        step();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        rf.i_rf_clr = 1'b1;
        exp_push("cb_clr", 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0);
        step();
        rf.i_rf_clr = 1'b0;
        set_wr(1'b1, 5'd6, 32'h00005678, 4'b1111);
        exp_push("cb_w6", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        exp_push("cb_err", 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 3; i <= 32; i++) begin
            step();
            rf.i_rf_clr = (i == 5);
            exp_push("cb_busy", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        step();
        rf.i_rf_clr = 1'b0;
        exp_push("cb_done", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        step();
        set_rd(5'd7, 5'd7);
        set_wr(1'b1, 5'd7, 32'hDEADBEEF, 4'b1111);
        exp_push("byp", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0,
                 BYP ? 32'hDEADBEEF : 32'h0, 1'b0, 1'b0);
        step();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        set_rd(5'd7, 5'd8);
        exp_push("byp_rd", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        step();
        rf.i_rf_clr = 1'b1;
        exp_push("ms_clr", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            step();
            rf.i_rf_clr = 1'b0;
            if (i == 11) i_rstn = 1'b0;
            exp_push("ms_busy", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        step();
        i_rstn = 1'b1;
        sweep_check("ms_sweep", 5'd7, 5'd7);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
